// File: rtl/hs_tx_param_pkg.sv
// Shared FSM state encoding and protocol-mode constants for the hs_tx_param
// bundled-data transmitter.
package hs_tx_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_e;

  localparam bit PROTO_4PH = 1'b1;
  localparam bit PROTO_2PH = 1'b0;

  localparam int unsigned MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/hs_tx_param_sync_chain.sv
// Multi-flop synchroniser for the asynchronous receiver acknowledge.
module hs_tx_param_sync_chain
  import hs_tx_param_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  // Depths below the metastability minimum are raised to it.
  localparam int unsigned N = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

  logic [N-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/hs_tx_param.sv
// Bundled-data req/ack transmitter: local FIFO feeding a 4-phase or 2-phase
// handshake towards an asynchronous receiver.
module hs_tx_param
  import hs_tx_param_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          MODE_4PH    = 1'b1,
  parameter int unsigned FIFO_AW     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vi,
  input  logic [DATA_W-1:0]   sdata,
  output logic                rdy,
  input  logic                ack,
  output logic                req,
  output logic [DATA_W-1:0]   data,
  output logic                snt,
  output logic [FIFO_AW:0]    level
);

  localparam int unsigned      DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW+1)'(DEPTH);
  localparam bit               IS_4PH   = (MODE_4PH == PROTO_4PH);

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;

  state_e             state_q, state_d;
  logic               req_q, req_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               snt_q, snt_d;

  logic               ack_s;
  logic               ack_d_q;
  logic               push;
  logic               pop;

  hs_tx_param_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (ack),
    .q_o   (ack_s)
  );

  assign rdy  = !reset && (level_q != FULL_LVL);
  assign push = vi && rdy;

  // FIFO storage carries no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sdata;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

  // Handshake FSM; data is only reloaded on the IDLE->SETUP transition.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    pop     = 1'b0;
    snt_d   = IS_4PH ? (ack_s && !ack_d_q) : (ack_s ^ ack_d_q);
    case (state_q)
      ST_IDLE: begin
        if (level_q != '0) begin
          data_d  = mem_q[rd_ptr_q];
          pop     = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        req_d   = IS_4PH ? 1'b1 : ~req_q;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (IS_4PH) begin
          if (ack_s) begin
            req_d   = 1'b0;
            state_d = ST_WAIT_REL;
          end
        end else if (ack_s == req_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_REL: begin
        if (!ack_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      req_q    <= 1'b0;
      data_q   <= '0;
      snt_q    <= 1'b0;
      ack_d_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      data_q   <= data_d;
      snt_q    <= snt_d;
      ack_d_q  <= ack_s;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign req   = req_q;
  assign data  = data_q;
  assign snt   = snt_q;
  assign level = level_q;

endmodule

// File: tb/tb_hs_tx_param.sv
// Bench for hs_tx_param: a 4-phase/2-stage instance and a 2-phase/3-stage
// instance, each driven by a receiver model and checked against a scoreboard.
module tb_hs_tx_param;

  localparam int RX_DLY = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       vi_a, vi_b;
  logic [7:0] sdata_a, sdata_b;
  logic       rdy_a, rdy_b;
  logic       ack_a, ack_b;
  logic       req_a, req_b;
  logic [7:0] data_a, data_b;
  logic       snt_a, snt_b;
  logic [2:0] level_a, level_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  int  rx_got_a = 0, rx_got_b = 0;
  int  snt_cnt_a = 0, snt_cnt_b = 0;
  bit  rx_busy_a = 1'b0;
  logic [7:0] ahist_a, ahist_b;

  always #5 clk = ~clk;

  hs_tx_param #(.DATA_W(8), .SYNC_STAGES(2), .MODE_4PH(1'b1), .FIFO_AW(2)) dut_a (
    .clk(clk), .reset(reset), .vi(vi_a), .sdata(sdata_a), .rdy(rdy_a), .ack(ack_a),
    .req(req_a), .data(data_a), .snt(snt_a), .level(level_a));

  hs_tx_param #(.DATA_W(8), .SYNC_STAGES(3), .MODE_4PH(1'b0), .FIFO_AW(2)) dut_b (
    .clk(clk), .reset(reset), .vi(vi_b), .sdata(sdata_b), .rdy(rdy_b), .ack(ack_b),
    .req(req_b), .data(data_b), .snt(snt_b), .level(level_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit sel_b, input logic [7:0] w, input bit exp_ok);
    if (!sel_b) begin
      chk("a_push_rdy", 32'(rdy_a), 32'(exp_ok));
      vi_a = 1'b1; sdata_a = w;
      if (exp_ok) exp_q_a.push_back(w);
    end else begin
      chk("b_push_rdy", 32'(rdy_b), 32'(exp_ok));
      vi_b = 1'b1; sdata_b = w;
      if (exp_ok) exp_q_b.push_back(w);
    end
    @(negedge clk);
    vi_a = 1'b0;
    vi_b = 1'b0;
  endtask

  task automatic drain_a();
    int n = 0;
    while ((exp_q_a.size() != 0 || rx_busy_a || req_a || level_a != 3'd0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("a_drain_timeout", 32'(n < 400), 32'd1);
    repeat (6) @(negedge clk);
  endtask

  // Ack history sampled on the same edges the DUT synchroniser samples.
  always @(posedge clk) begin
    if (reset) begin
      ahist_a <= '0;
      ahist_b <= '0;
    end else begin
      ahist_a <= {ahist_a[6:0], ack_a};
      ahist_b <= {ahist_b[6:0], ack_b};
    end
  end

  // 4-phase receiver: ack after RX_DLY, release RX_DLY after req falls.
  initial begin : rx_a
    bit abort;
    int n;
    ack_a = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && req_a && !ack_a) begin
        rx_busy_a = 1'b1;
        rx_got_a++;
        if (exp_q_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_a_extra: got %0h expected none", data_a);
        end else begin
          chk("rx_a_word", 32'(data_a), 32'(exp_q_a.pop_front()));
        end
        abort = 1'b0;
        for (int i = 0; i < RX_DLY; i++) begin
          @(negedge clk);
          if (reset) abort = 1'b1;
        end
        if (!abort) begin
          ack_a = 1'b1;
          n = 0;
          while (req_a && n < 64) begin
            @(negedge clk);
            n++;
          end
          chk("rx_a_req_fall", 32'(n < 64), 32'd1);
          for (int i = 0; i < RX_DLY; i++) @(negedge clk);
          ack_a = 1'b0;
        end
        rx_busy_a = 1'b0;
      end
    end
  end

  // 2-phase receiver: a req transition is answered by matching ack.
  initial begin : rx_b
    bit abort;
    ack_b = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && req_b !== ack_b) begin
        rx_got_b++;
        if (exp_q_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_b_extra: got %0h expected none", data_b);
        end else begin
          chk("rx_b_word", 32'(data_b), 32'(exp_q_b.pop_front()));
        end
        abort = 1'b0;
        for (int i = 0; i < RX_DLY; i++) begin
          @(negedge clk);
          if (reset) abort = 1'b1;
        end
        if (!abort) ack_b = req_b;
      end
    end
  end

  // Every-cycle checks: rdy/level relation, snt timing from ack history, data hold.
  logic       pr_req_a = 1'b0, pr_ack_a = 1'b0, pr_req_b = 1'b0, pr_ack_b = 1'b0, pr_rst = 1'b1;
  logic [7:0] pr_data_a = '0, pr_data_b = '0;
  always @(negedge clk) begin
    #2;
    if (reset) begin
      chk("a_rst_req", 32'(req_a), 32'd0);
      chk("a_rst_rdy", 32'(rdy_a), 32'd0);
      chk("a_rst_snt", 32'(snt_a), 32'd0);
      chk("b_rst_req", 32'(req_b), 32'd0);
      chk("b_rst_lvl", 32'(level_b), 32'd0);
    end else begin
      chk("a_rdy", 32'(rdy_a), 32'(level_a != 3'd4));
      chk("b_rdy", 32'(rdy_b), 32'(level_b != 3'd4));
      chk("a_snt", 32'(snt_a), 32'(ahist_a[2] & ~ahist_a[3]));
      chk("b_snt", 32'(snt_b), 32'(ahist_b[3] ^ ahist_b[4]));
      if (!pr_rst && (pr_req_a || pr_ack_a)) chk("a_data_hold", 32'(data_a), 32'(pr_data_a));
      if (!pr_rst && (pr_req_b != pr_ack_b)) chk("b_data_hold", 32'(data_b), 32'(pr_data_b));
      if (snt_a) snt_cnt_a++;
      if (snt_b) snt_cnt_b++;
    end
    pr_req_a = req_a; pr_ack_a = ack_a; pr_data_a = data_a;
    pr_req_b = req_b; pr_ack_b = ack_b; pr_data_b = data_b;
    pr_rst = reset;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : directed
    reset = 1'b1;
    vi_a = 1'b0; vi_b = 1'b0; sdata_a = '0; sdata_b = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_a_req",  32'(req_a),  32'd0);
    chk("rst_a_data", 32'(data_a), 32'd0);
    chk("rst_a_lvl",  32'(level_a), 32'd0);
    chk("rst_a_rdy",  32'(rdy_a),  32'd0);
    chk("rst_b_data", 32'(data_b), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", 32'(rdy_a), 32'd1);

    // Single 4-phase word
    push(1'b0, 8'hA5, 1'b1);
    chk("t1_lvl1", 32'(level_a), 32'd1);
    chk("t1_req0", 32'(req_a), 32'd0);
    @(negedge clk);
    chk("t1_data_pre", 32'(data_a), 32'hA5);
    chk("t1_req_pre", 32'(req_a), 32'd0);
    chk("t1_lvl0", 32'(level_a), 32'd0);
    @(negedge clk);
    chk("t1_req_rise", 32'(req_a), 32'd1);
    repeat (5) @(negedge clk);
    chk("t1_snt_early", 32'(snt_a), 32'd0);
    chk("t1_req_held", 32'(req_a), 32'd1);
    @(negedge clk);
    chk("t1_snt", 32'(snt_a), 32'd1);
    chk("t1_req_fall", 32'(req_a), 32'd0);
    @(negedge clk);
    chk("t1_snt_once", 32'(snt_a), 32'd0);
    drain_a();

    // Fill while a word is in flight; fifth push must be dropped
    push(1'b0, 8'h5A, 1'b1);
    repeat (2) @(negedge clk);
    chk("t2_busy_req", 32'(req_a), 32'd1);
    for (int i = 1; i <= 4; i++) push(1'b0, 8'(i), 1'b1);
    chk("t2_full_lvl", 32'(level_a), 32'd4);
    push(1'b0, 8'h05, 1'b0);
    chk("t2_full_lvl2", 32'(level_a), 32'd4);
    chk("t2_full_rdy", 32'(rdy_a), 32'd0);
    drain_a();

    // Push coincident with pop at level 2
    push(1'b0, 8'hC1, 1'b1);
    @(negedge clk);
    push(1'b0, 8'hC2, 1'b1);
    push(1'b0, 8'hC3, 1'b1);
    chk("t3_lvl2", 32'(level_a), 32'd2);
    repeat (11) @(negedge clk);
    chk("t3_lvl2_pre", 32'(level_a), 32'd2);
    chk("t3_req_low", 32'(req_a), 32'd0);
    push(1'b0, 8'hC4, 1'b1);
    chk("t3_lvl_same", 32'(level_a), 32'd2);
    chk("t3_data_c2", 32'(data_a), 32'hC2);
    @(negedge clk);
    chk("t3_req_c2", 32'(req_a), 32'd1);
    drain_a();

    // 2-phase instance, 3-stage synchroniser
    push(1'b1, 8'h11, 1'b1);
    push(1'b1, 8'h22, 1'b1);
    chk("t4_lvl", 32'(level_b), 32'd1);
    chk("t4_data11", 32'(data_b), 32'h11);
    chk("t4_req0", 32'(req_b), 32'd0);
    @(negedge clk);
    chk("t4_req_tog1", 32'(req_b), 32'd1);
    repeat (6) @(negedge clk);
    chk("t4_snt_early", 32'(snt_b), 32'd0);
    @(negedge clk);
    chk("t4_snt1", 32'(snt_b), 32'd1);
    @(negedge clk);
    chk("t4_snt1_once", 32'(snt_b), 32'd0);
    chk("t4_data22", 32'(data_b), 32'h22);
    chk("t4_req_hold", 32'(req_b), 32'd1);
    @(negedge clk);
    chk("t4_req_tog2", 32'(req_b), 32'd0);
    repeat (6) @(negedge clk);
    chk("t4_snt2_early", 32'(snt_b), 32'd0);
    @(negedge clk);
    chk("t4_snt2", 32'(snt_b), 32'd1);
    repeat (5) @(negedge clk);
    chk("t4_b_empty", 32'(exp_q_b.size()), 32'd0);

    // Reset while waiting for ack
    push(1'b0, 8'hE1, 1'b1);
    push(1'b0, 8'hE2, 1'b1);
    push(1'b0, 8'hE3, 1'b1);
    chk("t5_req1", 32'(req_a), 32'd1);
    chk("t5_lvl2", 32'(level_a), 32'd2);
    @(negedge clk);
    chk("t5_wait_req", 32'(req_a), 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_async_req", 32'(req_a), 32'd0);
    chk("t5_async_lvl", 32'(level_a), 32'd0);
    chk("t5_async_rdy", 32'(rdy_a), 32'd0);
    chk("t5_async_data", 32'(data_a), 32'd0);
    exp_q_a.delete();
    repeat (2) @(negedge clk);
    chk("t5_rdy_in_rst", 32'(rdy_a), 32'd0);
    reset = 1'b0;
    #1;
    chk("t5_rdy_after", 32'(rdy_a), 32'd1);
    @(negedge clk);
    push(1'b0, 8'hF1, 1'b1);
    drain_a();

    chk("end_snt_a", 32'(snt_cnt_a), 32'd11);
    chk("end_snt_b", 32'(snt_cnt_b), 32'd2);
    chk("end_rx_a", 32'(rx_got_a), 32'd12);
    chk("end_rx_b", 32'(rx_got_b), 32'd2);
    chk("end_q_a", 32'(exp_q_a.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
